// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding and
// the step-counter width helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(w)) + 1 bits, enough to hold step indices 0..w-1 with headroom.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/ripple_adder.sv
// Parametrised ripple-carry adder, sum only (carry-out is dropped).
module ripple_adder #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum_c
);

    always_comb begin : carry_chain
        logic c;
        c     = cin;
        sum_c = '0;
        for (int unsigned i = 0; i < W; i++) begin
            sum_c[i] = a[i] ^ b[i] ^ c;
            c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, W x W -> 2W, optional signed operands,
// one W+1-bit adder reused over W cycles, valid/ready on both sides.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);

    localparam int unsigned CW = cnt_width(W);
    localparam int unsigned PW = 2 * W;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    mcand;
    logic [W-1:0]    mq;
    logic [W:0]      acc_hi;
    logic            neg;
    logic [CW-1:0]   cnt;

    logic            accept_c;
    logic            last_step_c;
    logic            sgn_c;
    logic [W-1:0]    mag_a_c;
    logic [W-1:0]    mag_b_c;
    logic [W:0]      addend_c;
    logic [W:0]      sum_c;
    logic [PW-1:0]   prod_c;
    logic [PW-1:0]   prod_neg_c;
    logic            in_ready_nxt;
    logic            out_valid_nxt;
    logic            busy_nxt;

    assign accept_c    = in_valid && (state == IDLE);
    assign last_step_c = (state == RUN) && (cnt == CW'(W - 1));
    assign sgn_c       = SIGNED_EN && is_signed;

    // Operand magnitudes; -2^(W-1) negates to itself, which reads correctly as unsigned.
    always_comb begin
        mag_a_c = (sgn_c && a[W-1]) ? W'(-a) : a;
        mag_b_c = (sgn_c && b[W-1]) ? W'(-b) : b;
    end

    assign addend_c = mq[0] ? {1'b0, mcand} : '0;

    ripple_adder #(.W(W + 1)) u_step_add (
        .a     (acc_hi),
        .b     (addend_c),
        .cin   (1'b0),
        .sum_c (sum_c)
    );

    // Post-step product: {acc_hi[W-1:0], mq} after the shift equals {sum, mq[W-1:1]}.
    assign prod_c = {sum_c, mq[W-1:1]};

    ripple_adder #(.W(PW)) u_neg_add (
        .a     (~prod_c),
        .b     ({PW{1'b0}}),
        .cin   (1'b1),
        .sum_c (prod_neg_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)    state_nxt = RUN;
            RUN:     if (last_step_c) state_nxt = DONE;
            DONE:    if (out_ready)   state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the upcoming state and registered.
    always_comb begin
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        case (state_nxt)
            IDLE:    in_ready_nxt = 1'b1;
            RUN:     busy_nxt     = 1'b1;
            DONE: begin
                out_valid_nxt = 1'b1;
                busy_nxt      = 1'b1;
            end
            default: in_ready_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mq     <= '0;
            acc_hi <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            p      <= '0;
        end else if (accept_c) begin
            mcand  <= mag_a_c;
            mq     <= mag_b_c;
            neg    <= sgn_c && (a[W-1] ^ b[W-1]);
            acc_hi <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc_hi <= {1'b0, sum_c[W:1]};
            mq     <= {sum_c[0], mq[W-1:1]};
            cnt    <= CW'(cnt + 1'b1);
            if (last_step_c) p <= neg ? prod_neg_c : prod_c;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: cycle-level contract model for W=8,
// directed literal vectors, reset/back-pressure checks and W=2/W=16 regression.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        is_signed;
    logic        out_ready;

    logic        in_ready, out_valid, busy;
    logic [15:0] p;
    logic        in_ready_u, out_valid_u, busy_u;
    logic [15:0] p_u;

    logic        iv_r;
    logic        s_r;
    logic [1:0]  a2, b2;
    logic [15:0] a16, b16;
    logic        ir2, ov2, bz2, ir16, ov16, bz16;
    logic [3:0]  p2;
    logic [31:0] p16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.W(8), .SIGNED_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .p(p), .busy(busy)
    );

    seq_multiplier #(.W(8), .SIGNED_EN(1'b0)) u_dut_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid_u),
        .out_ready(out_ready), .p(p_u), .busy(busy_u)
    );

    seq_multiplier #(.W(2), .SIGNED_EN(1'b1)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_r), .in_ready(ir2),
        .a(a2), .b(b2), .is_signed(s_r), .out_valid(ov2),
        .out_ready(1'b1), .p(p2), .busy(bz2)
    );

    seq_multiplier #(.W(16), .SIGNED_EN(1'b1)) u_dut_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_r), .in_ready(ir16),
        .a(a16), .b(b16), .is_signed(s_r), .out_valid(ov16),
        .out_ready(1'b1), .p(p16), .busy(bz16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sx(input longint v, input int w, input bit s);
        if (s && v[w-1]) return v - (longint'(1) << w);
        return v;
    endfunction

    // Reference product: plain integer multiply, truncated to 2w bits.
    function automatic longint refp(input longint x, input longint y, input int w, input bit s);
        longint mask;
        mask = (longint'(1) << (2 * w)) - 1;
        return (sx(x, w, s) * sx(y, w, s)) & mask;
    endfunction

    // Contract model for the W=8 pair: 0 = idle, 1 = computing, 2 = result held.
    int          ph   = 0;
    int          left = 0;
    logic [15:0] m_p, m_pu, m_res, m_resu;

    always @(negedge clk) begin
        if (!rst_n) begin
            ph   = 0;
            left = 0;
            chk("rst in_ready", in_ready, 1'b1);
            chk("rst out_valid", out_valid, 1'b0);
            chk("rst busy", busy, 1'b0);
            chk("rst p", p, 16'h0);
        end else begin
            chk("in_ready", in_ready, ph == 0);
            chk("out_valid", out_valid, ph == 2);
            chk("busy", busy, ph != 0);
            chk("uns in_ready", in_ready_u, ph == 0);
            chk("uns out_valid", out_valid_u, ph == 2);
            chk("uns busy", busy_u, ph != 0);
            if (ph == 2) begin
                chk("model p", p, m_p);
                chk("model p_u", p_u, m_pu);
            end
            case (ph)
                0: if (in_valid) begin
                    m_res  = 16'(refp(longint'(a), longint'(b), 8, is_signed));
                    m_resu = 16'(refp(longint'(a), longint'(b), 8, 1'b0));
                    ph     = 1;
                    left   = 8;
                end
                1: begin
                    left--;
                    if (left == 0) begin
                        ph   = 2;
                        m_p  = m_res;
                        m_pu = m_resu;
                    end
                end
                default: if (out_ready) ph = 0;
            endcase
        end
    end

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic s,
                          input logic [15:0] exp, input logic [15:0] expu,
                          input int hold, input string name);
        int cyc;
        @(posedge clk); #1;
        a = x; b = y; is_signed = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~x; b = 8'h5A; is_signed = ~s;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " latency"}, cyc, 8);
        chk({name, " p"}, p, exp);
        chk({name, " p_u"}, p_u, expu);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, " hold p"}, p, exp);
            chk({name, " hold out_valid"}, out_valid, 1'b1);
            chk({name, " hold in_ready"}, in_ready, 1'b0);
            chk({name, " hold busy"}, busy, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " release in_ready"}, in_ready, 1'b1);
        chk({name, " release out_valid"}, out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x, y;
        logic       s;
        int         cyc;
        bit         got2, got16;

        rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
        iv_r = 1'b0; s_r = 1'b0; a2 = '0; b2 = '0; a16 = '0; b16 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("por in_ready", in_ready, 1'b1);
        chk("por out_valid", out_valid, 1'b0);
        chk("por busy", busy, 1'b0);
        chk("por p", p, 16'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(8'd13,  8'd11,  1'b0, 16'h008F, 16'h008F, 5, "u13x11");
        run_op(8'hFF,  8'hFF,  1'b0, 16'hFE01, 16'hFE01, 0, "uFFxFF");
        run_op(8'hFD,  8'd5,   1'b0, 16'h04F1, 16'h04F1, 0, "uFDx5");
        run_op(8'hFD,  8'd5,   1'b1, 16'hFFF1, 16'h04F1, 2, "sFDx5");
        run_op(8'h80,  8'h80,  1'b1, 16'h4000, 16'h4000, 0, "s80x80");
        run_op(8'hFF,  8'd2,   1'b1, 16'hFFFE, 16'h01FE, 0, "sFFx2");

        // Reset in the middle of RUN discards the operation.
        @(posedge clk); #1;
        a = 8'h55; b = 8'h33; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun rst in_ready", in_ready, 1'b1);
        chk("midrun rst out_valid", out_valid, 1'b0);
        chk("midrun rst busy", busy, 1'b0);
        chk("midrun rst p", p, 16'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        run_op(8'd7, 8'd6, 1'b0, 16'h002A, 16'h002A, 0, "after_rst");

        for (int k = 0; k < 6; k++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            s = 1'($urandom);
            run_op(x, y, s, 16'(refp(longint'(x), longint'(y), 8, s)),
                   16'(refp(longint'(x), longint'(y), 8, 1'b0)), k % 2, "rand8");
        end

        // W=2 exhaustive and W=16 random, accepted on the same edge.
        for (int k = 0; k < 32; k++) begin
            @(posedge clk); #1;
            a2  = 2'(k);
            b2  = 2'(k >> 2);
            s_r = 1'(k >> 4);
            a16 = (k == 0) ? 16'h8000 : 16'($urandom);
            b16 = (k == 0) ? 16'h8000 : 16'($urandom);
            if (k == 0) s_r = 1'b1;
            iv_r = 1'b1;
            @(posedge clk); #1;
            iv_r = 1'b0;
            cyc = 0; got2 = 1'b0; got16 = 1'b0;
            while (!(got2 && got16) && cyc < 60) begin
                if (ov2 && !got2) begin
                    got2 = 1'b1;
                    chk("w2 latency", cyc, 2);
                    chk("w2 p", p2, refp(longint'(a2), longint'(b2), 2, s_r));
                end
                if (ov16 && !got16) begin
                    got16 = 1'b1;
                    chk("w16 latency", cyc, 16);
                    chk("w16 p", p16, refp(longint'(a16), longint'(b16), 16, s_r));
                end
                @(posedge clk); #1;
                cyc++;
            end
            chk("w2 result seen", got2, 1'b1);
            chk("w16 result seen", got16, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
